// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: mult/div FSM encoding,
// tuse/tnew width, default busy-cycle counts and the register-hazard test.
package hazard_ctrl_pkg;

  localparam int TW              = 2;
  localparam int CNT_W           = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Producer result arrives too late for the consumer: stall.
  function automatic logic reg_hazard(input logic [4:0]    src,
                                      input logic [TW-1:0] tuse,
                                      input logic [4:0]    wa,
                                      input logic [TW-1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_fsm.sv
// Mult/div busy tracker: counts the fixed latency of one multiply or divide
// and flags busy plus a done pulse in the final busy cycle.
module md_busy_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a start while busy is ignored, so only IDLE looks at start_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (is_div_i) begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_CYCLES);
          end else begin
            state_d = MULT;
            cnt_d   = CNT_W'(MULT_CYCLES);
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end
      end
      MULT, DIV: begin
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d   = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q != IDLE) && (cnt_q == 5'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall from register and mult/div
// hazards, PC/IF-ID/ID-EX controls, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_D,
  input  logic [4:0]    rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic          is_md_D,
  input  logic [4:0]    wa_E,
  input  logic [4:0]    wa_M,
  input  logic [TW-1:0] tnew_E,
  input  logic [TW-1:0] tnew_M,
  input  logic          md_start_i,
  input  logic          md_is_div_i,
  output logic          stall_o,
  output logic          pc_en_o,
  output logic          fd_en_o,
  output logic          de_clr_o,
  output logic          md_busy_o,
  output logic          md_done_o,
  output logic [31:0]   stall_cnt_o
);

  logic        reg_hz_s;
  logic        md_hz_s;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_fsm (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start_i),
    .is_div_i (md_is_div_i),
    .busy_o   (md_busy_o),
    .done_o   (md_done_o)
  );

  assign reg_hz_s = reg_hazard(rs_D, tuse_rs_D, wa_E, tnew_E) ||
                    reg_hazard(rs_D, tuse_rs_D, wa_M, tnew_M) ||
                    reg_hazard(rt_D, tuse_rt_D, wa_E, tnew_E) ||
                    reg_hazard(rt_D, tuse_rt_D, wa_M, tnew_M);

  assign md_hz_s  = is_md_D && (md_start_i || md_busy_o);

  assign stall_o  = reg_hz_s || md_hz_s;
  assign pc_en_o  = !stall_o;
  assign fd_en_o  = !stall_o;
  assign de_clr_o = stall_o;

  // Stall counter next value, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change just after each falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, wa_E, wa_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        is_md_D, md_start_i, md_is_div_i;
  logic        stall_o, pc_en_o, fd_en_o, de_clr_o, md_busy_o, md_done_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .is_md_D     (is_md_D),
    .wa_E        (wa_E),
    .wa_M        (wa_M),
    .tnew_E      (tnew_E),
    .tnew_M      (tnew_M),
    .md_start_i  (md_start_i),
    .md_is_div_i (md_is_div_i),
    .stall_o     (stall_o),
    .pc_en_o     (pc_en_o),
    .fd_en_o     (fd_en_o),
    .de_clr_o    (de_clr_o),
    .md_busy_o   (md_busy_o),
    .md_done_o   (md_done_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hz();
    rs_D = 5'd0; rt_D = 5'd0; wa_E = 5'd0; wa_M = 5'd0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 2'd0; tnew_M = 2'd0;
  endtask

  task automatic stall_chk(input string tag, input logic exp);
    #1;
    check({tag, ".stall"},  {31'd0, stall_o},  {31'd0, exp});
    check({tag, ".pc_en"},  {31'd0, pc_en_o},  {31'd0, !exp});
    check({tag, ".fd_en"},  {31'd0, fd_en_o},  {31'd0, !exp});
    check({tag, ".de_clr"}, {31'd0, de_clr_o}, {31'd0, exp});
  endtask

  task automatic md_chk(input string tag, input logic busy, input logic done);
    #1;
    check({tag, ".busy"}, {31'd0, md_busy_o}, {31'd0, busy});
    check({tag, ".done"}, {31'd0, md_done_o}, {31'd0, done});
  endtask

  initial begin
    reset = 1'b1;
    clear_hz();
    is_md_D = 1'b0; md_start_i = 1'b0; md_is_div_i = 1'b0;

    // Reset state with all hazard inputs quiet.
    tuse_rs_D = 2'd0; tuse_rt_D = 2'd0;
    @(negedge clk);
    stall_chk("reset", 1'b0);
    md_chk("reset", 1'b0, 1'b0);
    check("reset.stall_cnt", stall_cnt_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_hz();

    // Load-use on rs through E, then resolved once the load is in M.
    wa_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    stall_chk("load_use", 1'b1);
    @(negedge clk);
    wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd8; tnew_M = 2'd1;
    stall_chk("load_use_m", 1'b0);
    check("load_use.stall_cnt", stall_cnt_o, 32'd1);

    // Combinational register-hazard cases within one low phase.
    clear_hz();
    wa_E = 5'd8; tnew_E = 2'd1; rt_D = 5'd8; tuse_rt_D = 2'd1;
    stall_chk("alu_fwd", 1'b0);
    wa_E = 5'd0; rt_D = 5'd0;
    stall_chk("zero_reg", 1'b0);
    tnew_E = 2'd2;
    stall_chk("zero_reg_t2", 1'b0);
    wa_E = 5'd8; rt_D = 5'd8; tnew_E = 2'd2;
    stall_chk("rt_hz", 1'b1);
    tuse_rt_D = 2'd3;
    stall_chk("tuse_none", 1'b0);
    tuse_rt_D = 2'd2;
    stall_chk("tnew_eq_tuse", 1'b0);
    clear_hz();
    wa_E = 5'd9; tnew_E = 2'd0; wa_M = 5'd9; tnew_M = 2'd2; rs_D = 5'd9; tuse_rs_D = 2'd1;
    stall_chk("em_both_m", 1'b1);
    tnew_E = 2'd1; tnew_M = 2'd0; tuse_rs_D = 2'd0;
    stall_chk("em_both_e", 1'b1);
    wa_M = 5'd7; tnew_M = 2'd2; rt_D = 5'd7; tuse_rt_D = 2'd1; wa_E = 5'd0;
    stall_chk("rt_m", 1'b1);
    clear_hz();
    stall_chk("cleared", 1'b0);
    @(negedge clk);
    check("comb.stall_cnt", stall_cnt_o, 32'd1);

    // Mult: one start cycle then exactly five busy cycles.
    is_md_D = 1'b1; md_start_i = 1'b1; md_is_div_i = 1'b0;
    stall_chk("mult_start", 1'b1);
    md_chk("mult_start", 1'b0, 1'b0);
    @(negedge clk);
    md_start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      md_chk($sformatf("mult_b%0d", k), 1'b1, k == 5);
      stall_chk($sformatf("mult_b%0d", k), 1'b1);
      @(negedge clk);
    end
    md_chk("mult_end", 1'b0, 1'b0);
    stall_chk("mult_end", 1'b0);
    check("mult.stall_cnt", stall_cnt_o, 32'd7);
    is_md_D = 1'b0;

    // Div with a restart attempt at busy cycle 3 that must be ignored.
    md_start_i = 1'b1; md_is_div_i = 1'b1;
    @(negedge clk);
    md_start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      md_start_i = (k == 3);
      md_is_div_i = 1'b0;
      md_chk($sformatf("div_b%0d", k), 1'b1, k == 10);
      @(negedge clk);
    end
    md_start_i = 1'b0;
    md_chk("div_end", 1'b0, 1'b0);
    check("div.stall_cnt", stall_cnt_o, 32'd7);

    // Reset in the middle of a divide aborts it.
    is_md_D = 1'b1; md_start_i = 1'b1; md_is_div_i = 1'b1;
    @(negedge clk);
    md_start_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      md_chk($sformatf("rdiv_b%0d", k), 1'b1, 1'b0);
      @(negedge clk);
    end
    md_chk("rdiv_b4", 1'b1, 1'b0);
    check("rdiv.stall_cnt_pre", stall_cnt_o, 32'd11);
    reset = 1'b1;
    md_chk("rdiv_reset", 1'b0, 1'b0);
    check("rdiv.stall_cnt", stall_cnt_o, 32'd0);
    stall_chk("rdiv_reset", 1'b0);
    @(negedge clk);
    md_chk("rdiv_held", 1'b0, 1'b0);
    check("rdiv_held.stall_cnt", stall_cnt_o, 32'd0);

    // First start after reset release is taken on the very next edge.
    reset = 1'b0; is_md_D = 1'b0; md_start_i = 1'b1; md_is_div_i = 1'b0;
    @(negedge clk);
    md_start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      md_chk($sformatf("post_rst_b%0d", k), 1'b1, k == 5);
      @(negedge clk);
    end
    md_chk("post_rst_end", 1'b0, 1'b0);

    // Saturation of the stall counter under a continuous hazard.
    wa_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    stall_chk("sat", 1'b1);
    check("sat.pre", stall_cnt_o, 32'hFFFF_FFFE);
    @(negedge clk);
    check("sat.max", stall_cnt_o, 32'hFFFF_FFFF);
    @(negedge clk);
    check("sat.hold", stall_cnt_o, 32'hFFFF_FFFF);
    @(negedge clk);
    check("sat.hold2", stall_cnt_o, 32'hFFFF_FFFF);
    clear_hz();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
